// File: rtl/pong_pkg.sv
// Shared pong definitions: match state encoding, default match timing/scoring,
// and screen geometry shared with the playfield and ball datapath.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   localparam int SERVE_FRAMES_DEF = 60;
   localparam int PAUSE_FRAMES_DEF = 90;
   localparam int WIN_SCORE_DEF    = 11;
   localparam int SCORE_W_DEF      = 4;

   localparam int SCREEN_W     = 640;
   localparam int SCREEN_H     = 480;
   localparam int BALL_SIZE    = 8;
   localparam int PADDLE_W     = 8;
   localparam int PADDLE_H     = 64;
   localparam int PADDLE_X_OFS = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame tick from vsync rising edge, frame counter with clear, and a
// terminal-count flag that fires on the tick where the count hits limit_i.
module pong_frame_timer #(
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vsync,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             done_o
);

   logic             vsync_q;
   logic [CNT_W-1:0] cnt_q;
   logic             tick;

   assign tick   = vsync & ~vsync_q;
   assign done_o = tick && (cnt_q == limit_i);

   // Clear wins over tick so a tick coinciding with a state change is
   // consumed by the old state and the new state starts counting at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         vsync_q <= vsync;
         if (clr_i)
            cnt_q <= '0;
         else if (tick)
            cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve hold, play, post-point freeze and game-over,
// with saturating per-player scores and a registered point strobe.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
   parameter int PAUSE_FRAMES = PAUSE_FRAMES_DEF,
   parameter int WIN_SCORE    = WIN_SCORE_DEF,
   parameter int SCORE_W      = SCORE_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vsync,
   input  logic               start,
   input  logic               miss_left,
   input  logic               miss_right,
   output logic               ball_run,
   output logic               ball_center,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               point,
   output logic               game_over,
   output logic               winner,
   output logic [2:0]         state
);

   localparam int CNT_W = $clog2(max_int(SERVE_FRAMES, PAUSE_FRAMES) + 1);
   localparam logic [CNT_W-1:0]   SERVE_LIM = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0]   PAUSE_LIM = CNT_W'(PAUSE_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] score1_q, score2_q;
   logic               serve_dir_q, point_q, start_armed_q;
   logic               frame_done, miss_r_only, miss_l_only;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s >= WIN) ? WIN : s + 1'b1;
   endfunction

   pong_frame_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .vsync   (vsync),
      .clr_i   (state_d != state_q),
      .limit_i ((state_q == ST_PAUSE) ? PAUSE_LIM : SERVE_LIM),
      .done_o  (frame_done)
   );

   assign miss_r_only = miss_right & ~miss_left;
   assign miss_l_only = miss_left & ~miss_right;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_SERVE;
         ST_SERVE: if (frame_done) state_d = ST_PLAY;
         ST_PLAY: begin
            if (miss_left && miss_right)
               state_d = ST_PAUSE;
            else if (miss_right)
               state_d = (sat_inc(score1_q) == WIN) ? ST_OVER : ST_PAUSE;
            else if (miss_left)
               state_d = (sat_inc(score2_q) == WIN) ? ST_OVER : ST_PAUSE;
         end
         ST_PAUSE: if (frame_done) state_d = ST_SERVE;
         ST_OVER:  if (start && start_armed_q) state_d = ST_SERVE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         score1_q      <= '0;
         score2_q      <= '0;
         serve_dir_q   <= 1'b0;
         point_q       <= 1'b0;
         start_armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         point_q <= 1'b0;
         if (state_q == ST_PLAY && miss_r_only) begin
            score1_q    <= sat_inc(score1_q);
            serve_dir_q <= 1'b0;
            point_q     <= 1'b1;
         end else if (state_q == ST_PLAY && miss_l_only) begin
            score2_q    <= sat_inc(score2_q);
            serve_dir_q <= 1'b1;
            point_q     <= 1'b1;
         end
         if ((state_q == ST_IDLE || state_q == ST_OVER) && state_d == ST_SERVE) begin
            score1_q    <= '0;
            score2_q    <= '0;
            serve_dir_q <= 1'b0;
         end
         // A restart from OVER needs start to have been seen low since entry.
         if (state_q != ST_OVER)
            start_armed_q <= 1'b0;
         else if (!start)
            start_armed_q <= 1'b1;
      end
   end

   assign ball_run    = (state_q == ST_PLAY);
   assign ball_center = (state_q == ST_IDLE) || (state_q == ST_SERVE) || (state_q == ST_OVER);
   assign game_over   = (state_q == ST_OVER);
   assign winner      = (state_q == ST_OVER) && (score2_q == WIN);
   assign serve_dir   = serve_dir_q;
   assign score1      = score1_q;
   assign score2      = score2_q;
   assign point       = point_q;
   assign state       = state_q;

endmodule
